// File: rtl/link_sched_pkg.sv
// Shared types and constants for the link token scheduler.
//   state_t  : scheduler FSM states
//   track_t  : one in-flight record held in the in-order tracking FIFO
//   make_id  : builds a token ID from the requester index and sequence number
package link_sched_pkg;

  localparam int TOKEN_W    = 32;
  localparam int ID_REQ_MSB = 31;
  localparam int ID_REQ_LSB = 16;
  localparam int ID_REQ_W   = ID_REQ_MSB - ID_REQ_LSB + 1;
  localparam int ID_SEQ_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [TOKEN_W-1:0] id;
    logic [TOKEN_W-1:0] clk_cnt;
  } track_t;

  function automatic logic [TOKEN_W-1:0] make_id(input logic [ID_REQ_W-1:0] req_idx,
                                                  input logic [ID_SEQ_W-1:0] seq);
    return {req_idx, seq};
  endfunction

endpackage

// File: rtl/link_sched_rr_arb.sv
// Combinational round-robin arbiter.
//   enable   : arbitration allowed this cycle; when low no grant is issued
//   req      : request vector
//   ptr      : highest-priority index (search starts here and wraps)
//   grant    : one-hot grant, zero when nothing is granted
//   valid    : a grant was issued
//   winner   : index of the granted requester
//   next_ptr : winner + 1 modulo N_REQ (pointer value after this grant)
module link_sched_rr_arb #(
  parameter int N_REQ = 4,
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic             valid,
  output logic [PTR_W-1:0] winner,
  output logic [PTR_W-1:0] next_ptr
);

  logic [PTR_W-1:0] idx;

  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant  = '0;
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    // Scan from the pointer upward with wrap; the first set request wins.
    for (int i = 0; i < N_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % N_REQ);
      if (enable && !valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
    if (valid) grant[winner] = 1'b1;
  end

  assign next_ptr = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + 1'b1;

endmodule

// File: rtl/link_token_sched.sv
// Link chain head scheduler.
// Shares one injection port among N_REQ requesters (round-robin), stamps each
// token with an ID {requester, seq} and the issue cycle count, keeps at most
// MAX_OUT tokens in flight, and matches returns against issue order to report
// round-trip time.
//   i_start/i_num_tokens : start a run of i_num_tokens tokens (IDLE only)
//   i_req/i_req_token    : per-requester request and 32-bit payload
//   o_grant              : combinational one-hot grant in the accept cycle
//   o_wen/o_token/o_clk_cnt/o_id : registered chain-head write
//   i_wen/i_token/i_clk_cnt/i_id : chain-tail return
//   o_rtt_valid/o_rtt/o_rtt_id   : round-trip result, one cycle after return
//   o_outstanding        : tokens in flight
//   o_err                : ID mismatch or return with nothing in flight
//   o_done               : run-complete pulse; o_busy : not IDLE
module link_token_sched
  import link_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MAX_OUT = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic                         i_start,
  input  logic [TOKEN_W-1:0]           i_num_tokens,
  input  logic [N_REQ-1:0]             i_req,
  input  logic [N_REQ*TOKEN_W-1:0]     i_req_token,
  output logic [N_REQ-1:0]             o_grant,
  output logic                         o_wen,
  output logic [TOKEN_W-1:0]           o_token,
  output logic [TOKEN_W-1:0]           o_clk_cnt,
  output logic [TOKEN_W-1:0]           o_id,
  input  logic                         i_wen,
  input  logic [TOKEN_W-1:0]           i_token,
  input  logic [TOKEN_W-1:0]           i_clk_cnt,
  input  logic [TOKEN_W-1:0]           i_id,
  output logic                         o_rtt_valid,
  output logic [TOKEN_W-1:0]           o_rtt,
  output logic [TOKEN_W-1:0]           o_rtt_id,
  output logic [$clog2(MAX_OUT+1)-1:0] o_outstanding,
  output logic                         o_err,
  output logic                         o_done,
  output logic                         o_busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int AW    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  state_t               state, state_next;
  logic [TOKEN_W-1:0]   clk_cnt;
  logic [TOKEN_W-1:0]   remaining;
  logic [ID_SEQ_W-1:0]  seq;
  logic [PTR_W-1:0]     rr_ptr;

  track_t               fifo_mem [MAX_OUT];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  track_t               head;

  logic                 inject_ok;
  logic [N_REQ-1:0]     arb_grant;
  logic                 arb_valid;
  logic [PTR_W-1:0]     arb_winner;
  logic [PTR_W-1:0]     arb_next_ptr;
  logic [TOKEN_W-1:0]   token_sel;

  logic                 do_push;
  logic                 do_pop;
  logic                 ret_err;

  // --------------------------------------------------------------------------
  // Injection arbitration
  // --------------------------------------------------------------------------
  assign inject_ok = (state == RUN) && (remaining != '0) && (count < CNT_W'(MAX_OUT));

  link_sched_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .enable   (inject_ok),
    .req      (i_req),
    .ptr      (rr_ptr),
    .grant    (arb_grant),
    .valid    (arb_valid),
    .winner   (arb_winner),
    .next_ptr (arb_next_ptr)
  );

  assign o_grant = arb_grant;
  assign do_push = arb_valid;

  always_comb begin
    token_sel = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (arb_winner == PTR_W'(r)) token_sel = i_req_token[r*TOKEN_W +: TOKEN_W];
    end
  end

  // --------------------------------------------------------------------------
  // Return matching. A return with nothing in flight never pops, so the
  // occupancy cannot underflow even when stale tokens come back after reset.
  // --------------------------------------------------------------------------
  assign head    = fifo_mem[rd_ptr];
  assign do_pop  = i_wen && (count != '0);
  assign ret_err = i_wen && ((count == '0) || (i_id != head.id));

  // The returned payload and the stored issue time travel with the token for
  // debug visibility; the RTT itself uses the stamp carried back by the chain.
  logic unused_return_bits;
  assign unused_return_bits = ^{i_token, head.clk_cnt};

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_start) state_next = (i_num_tokens == '0) ? DONE : RUN;
      RUN:     if (do_push && (remaining == TOKEN_W'(1))) state_next = DRAIN;
      DRAIN:   if (count == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      remaining   <= '0;
      seq         <= '0;
      rr_ptr      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_wen       <= 1'b0;
      o_token     <= '0;
      o_clk_cnt   <= '0;
      o_id        <= '0;
      o_rtt_valid <= 1'b0;
      o_rtt       <= '0;
      o_rtt_id    <= '0;
      o_err       <= 1'b0;
    end else begin
      state   <= state_next;
      clk_cnt <= clk_cnt + TOKEN_W'(1);

      if ((state == IDLE) && i_start) remaining <= i_num_tokens;
      else if (do_push)               remaining <= remaining - TOKEN_W'(1);

      o_wen <= do_push;
      if (do_push) begin
        o_token   <= token_sel;
        o_id      <= make_id(ID_REQ_W'(arb_winner), seq);
        o_clk_cnt <= clk_cnt;
        seq       <= seq + ID_SEQ_W'(1);
        rr_ptr    <= arb_next_ptr;
        wr_ptr    <= (wr_ptr == AW'(MAX_OUT - 1)) ? '0 : wr_ptr + 1'b1;
      end

      if (do_pop) rd_ptr <= (rd_ptr == AW'(MAX_OUT - 1)) ? '0 : rd_ptr + 1'b1;

      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      o_rtt_valid <= do_pop;
      o_err       <= ret_err;
      if (do_pop) begin
        // Modular subtraction keeps the RTT correct across counter wrap.
        o_rtt    <= clk_cnt - i_clk_cnt;
        o_rtt_id <= i_id;
      end
    end
  end

  // NOTE: the tracking storage has no reset; occupancy and pointers are reset,
  // so stale entries are never read as valid.
  always_ff @(posedge i_clk) begin
    if (do_push) fifo_mem[wr_ptr] <= '{id: make_id(ID_REQ_W'(arb_winner), seq), clk_cnt: clk_cnt};
  end

  assign o_outstanding = count;
  assign o_done        = (state == DONE);
  assign o_busy        = (state != IDLE);

endmodule

// File: tb/tb_link_token_sched.sv
// Self-checking bench for link_token_sched. Inputs change on the falling edge;
// outputs are sampled 1 time unit later, still well before the rising edge.
// A delay-line model of the link chain loops written tokens back to the tail.
module tb_link_token_sched;

  localparam int N_REQ   = 4;
  localparam int MAX_OUT = 4;

  logic                   i_clk = 1'b0;
  logic                   i_rstn = 1'b0;
  logic                   i_start = 1'b0;
  logic [31:0]            i_num_tokens = '0;
  logic [N_REQ-1:0]       i_req = '0;
  logic [N_REQ*32-1:0]    i_req_token;
  logic [N_REQ-1:0]       o_grant;
  logic                   o_wen;
  logic [31:0]            o_token, o_clk_cnt, o_id;
  logic                   i_wen = 1'b0;
  logic [31:0]            i_token = '0, i_clk_cnt = '0, i_id = '0;
  logic                   o_rtt_valid;
  logic [31:0]            o_rtt, o_rtt_id;
  logic [2:0]             o_outstanding;
  logic                   o_err, o_done, o_busy;

  link_token_sched #(.N_REQ(N_REQ), .MAX_OUT(MAX_OUT)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_num_tokens(i_num_tokens),
    .i_req(i_req), .i_req_token(i_req_token), .o_grant(o_grant),
    .o_wen(o_wen), .o_token(o_token), .o_clk_cnt(o_clk_cnt), .o_id(o_id),
    .i_wen(i_wen), .i_token(i_token), .i_clk_cnt(i_clk_cnt), .i_id(i_id),
    .o_rtt_valid(o_rtt_valid), .o_rtt(o_rtt), .o_rtt_id(o_rtt_id),
    .o_outstanding(o_outstanding), .o_err(o_err), .o_done(o_done), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  assign i_req_token = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Cycle driver and chain model
  // ---------------------------------------------------------------------------
  typedef struct {
    int          due;
    logic [31:0] token;
    logic [31:0] cnt;
    logic [31:0] id;
  } ret_t;

  ret_t        chain_q[$];
  ret_t        ret_e;
  int          delay = 5;
  bit          loop_en = 1'b1;
  bit          corrupt_en = 1'b0;
  logic [31:0] corrupt_from = '0, corrupt_to = '0;
  bit          man_wen = 1'b0;
  logic [31:0] man_id = '0, man_cnt = '0;
  logic        nx_start = 1'b0, nx_rstn = 1'b0;
  logic [3:0]  nx_req = '0;
  logic [31:0] nx_num = '0;
  int          k = 0;     // cycles since reset release == expected counter value
  int          tcyc = 0;  // monotonic cycle index for the chain model

  task automatic cycle();
    @(negedge i_clk);
    tcyc++;
    k++;
    if (!i_rstn && nx_rstn) k = 0;
    i_rstn       = nx_rstn;
    i_start      = nx_start;
    nx_start     = 1'b0;
    i_req        = nx_req;
    i_num_tokens = nx_num;
    i_wen        = 1'b0;
    i_id         = '0;
    i_clk_cnt    = '0;
    i_token      = '0;
    if (loop_en && chain_q.size() > 0 && chain_q[0].due <= tcyc) begin
      ret_e     = chain_q.pop_front();
      i_wen     = 1'b1;
      i_token   = ret_e.token;
      i_clk_cnt = ret_e.cnt;
      i_id      = (corrupt_en && ret_e.id == corrupt_from) ? corrupt_to : ret_e.id;
    end
    if (man_wen) begin
      i_wen     = 1'b1;
      i_id      = man_id;
      i_clk_cnt = man_cnt;
      man_wen   = 1'b0;
    end
    #1;
    if (o_wen) chain_q.push_back('{tcyc + delay, o_token, o_clk_cnt, o_id});
  endtask

  task automatic do_reset();
    nx_rstn = 1'b0;
    nx_req  = '0;
    cycle();
    cycle();
    nx_rstn = 1'b1;
    cycle();
  endtask

  function automatic int gidx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return -1;
  endfunction

  // ---------------------------------------------------------------------------
  // Vector table: single requester, 3 tokens, chain delay 5
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        start;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic        wen;
    logic [31:0] id;
    logic [31:0] cnt;
    logic        rv;
    logic [31:0] rtt_id;
    logic [2:0]  outst;
    logic        done;
    logic        busy;
  } vec_t;

  vec_t tbl [13];

  int  n_g, n_rv, n_err, max_o, first_rv, g5, bad_rtt, seen;
  bit  done_seen, prev_co;
  int  order [8];

  initial begin
    tbl[0]  = '{1'b1, 4'h1, 4'h0, 1'b0, 32'h0, 32'd0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'h1, 4'h1, 1'b0, 32'h0, 32'd0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 4'h1, 4'h1, 1'b1, 32'h0, 32'd2, 1'b0, 32'h0, 3'd1, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 4'h1, 4'h1, 1'b1, 32'h1, 32'd3, 1'b0, 32'h0, 3'd2, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 4'h1, 4'h0, 1'b1, 32'h2, 32'd4, 1'b0, 32'h0, 3'd3, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 4'h1, 4'h0, 1'b0, 32'h0, 32'd0, 1'b0, 32'h0, 3'd3, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 4'h1, 4'h0, 1'b0, 32'h0, 32'd0, 1'b0, 32'h0, 3'd3, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 4'h1, 4'h0, 1'b0, 32'h0, 32'd0, 1'b0, 32'h0, 3'd3, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 4'h1, 4'h0, 1'b0, 32'h0, 32'd0, 1'b1, 32'h0, 3'd2, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 4'h1, 4'h0, 1'b0, 32'h0, 32'd0, 1'b1, 32'h1, 3'd1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 4'h1, 4'h0, 1'b0, 32'h0, 32'd0, 1'b1, 32'h2, 3'd0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 4'h1, 4'h0, 1'b0, 32'h0, 32'd0, 1'b0, 32'h0, 3'd0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 4'h1, 4'h0, 1'b0, 32'h0, 32'd0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0};

    // ---- reset state ----
    do_reset();
    check("rst_busy", {31'b0, o_busy}, 32'd0);
    check("rst_outst", {29'b0, o_outstanding}, 32'd0);
    check("rst_flags", {28'b0, o_wen, o_rtt_valid, o_err, o_done}, 32'd0);
    check("rst_clk_cnt", o_clk_cnt, 32'd0);

    // ---- table: single requester ----
    delay = 5;
    chain_q.delete();
    for (int r = 0; r < 13; r++) begin
      nx_start = tbl[r].start;
      nx_req   = tbl[r].req;
      nx_num   = 32'd3;
      cycle();
      check($sformatf("t%0d_grant", r), {28'b0, o_grant}, {28'b0, tbl[r].grant});
      check($sformatf("t%0d_wen", r), {31'b0, o_wen}, {31'b0, tbl[r].wen});
      check($sformatf("t%0d_rv", r), {31'b0, o_rtt_valid}, {31'b0, tbl[r].rv});
      check($sformatf("t%0d_outst", r), {29'b0, o_outstanding}, {29'b0, tbl[r].outst});
      check($sformatf("t%0d_done", r), {31'b0, o_done}, {31'b0, tbl[r].done});
      check($sformatf("t%0d_busy", r), {31'b0, o_busy}, {31'b0, tbl[r].busy});
      check($sformatf("t%0d_err", r), {31'b0, o_err}, 32'd0);
      if (tbl[r].wen) begin
        check($sformatf("t%0d_id", r), o_id, tbl[r].id);
        check($sformatf("t%0d_cnt", r), o_clk_cnt, tbl[r].cnt);
        check($sformatf("t%0d_token", r), o_token, 32'hCAFE_0000);
      end
      if (tbl[r].rv) begin
        check($sformatf("t%0d_rtt", r), o_rtt, 32'd6);
        check($sformatf("t%0d_rtt_id", r), o_rtt_id, tbl[r].rtt_id);
      end
    end

    // ---- zero tokens: straight to DONE, no writes ----
    nx_req = 4'h1; nx_num = 32'd0; nx_start = 1'b1;
    cycle();
    check("zero_s0_done", {31'b0, o_done}, 32'd0);
    cycle();
    check("zero_s1_done", {31'b0, o_done}, 32'd1);
    check("zero_s1_wen", {28'b0, o_grant, o_wen} == 0 ? 32'd0 : 32'd1, 32'd0);
    cycle();
    check("zero_s2_done", {31'b0, o_done}, 32'd0);
    check("zero_s2_busy", {31'b0, o_busy}, 32'd0);
    check("zero_s2_wen", {31'b0, o_wen}, 32'd0);
    nx_req = '0;

    // ---- round-robin, full window, delay 10 ----
    do_reset();
    chain_q.delete();
    delay = 10;
    nx_req = 4'hF; nx_num = 32'd8; nx_start = 1'b1;
    n_g = 0; n_rv = 0; n_err = 0; max_o = 0; first_rv = -1; g5 = -2; bad_rtt = 0; done_seen = 0;
    for (int c = 0; c < 200 && !done_seen; c++) begin
      cycle();
      if (o_grant != '0) begin
        check($sformatf("rr_onehot_%0d", n_g), 32'($onehot(o_grant)), 32'd1);
        if (n_g < 8) order[n_g] = gidx(o_grant);
        if (n_g == 4) g5 = tcyc;
        n_g++;
      end
      if (o_wen) check($sformatf("rr_token_%0d", o_id[15:0]), o_token, 32'hCAFE_0000 | {16'h0, o_id[31:16]});
      if (int'(o_outstanding) > max_o) max_o = int'(o_outstanding);
      if (o_rtt_valid) begin
        n_rv++;
        if (first_rv < 0) first_rv = tcyc;
        if (o_rtt != 32'd11) bad_rtt++;
      end
      if (o_err) n_err++;
      if (o_done) done_seen = 1'b1;
    end
    nx_req = '0;
    check("rr_done", {31'b0, done_seen}, 32'd1);
    check("rr_grants", n_g, 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("rr_order_%0d", i), order[i], i % 4);
    check("rr_max_outst", max_o, 32'd4);
    check("rr_stall_until_return", g5, first_rv);
    check("rr_rtt_bad", bad_rtt, 32'd0);
    check("rr_rv_count", n_rv, 32'd8);
    check("rr_err", n_err, 32'd0);

    // ---- same-cycle inject and return at outstanding 3 ----
    do_reset();
    chain_q.delete();
    delay = 2;
    nx_req = 4'h1; nx_num = 32'd6; nx_start = 1'b1;
    seen = 0; n_err = 0; prev_co = 1'b0; done_seen = 0;
    for (int c = 0; c < 100 && !done_seen; c++) begin
      cycle();
      if (prev_co) check($sformatf("same_outst_%0d", seen), {29'b0, o_outstanding}, 32'd3);
      prev_co = (o_grant != '0) && i_wen && (o_outstanding == 3'd3);
      if (prev_co) seen++;
      if (o_err) n_err++;
      if (o_done) done_seen = 1'b1;
    end
    nx_req = '0;
    check("same_done", {31'b0, done_seen}, 32'd1);
    check("same_seen", {31'b0, seen != 0}, 32'd1);
    check("same_err", n_err, 32'd0);

    // ---- ID mismatch, then return with nothing in flight ----
    do_reset();
    chain_q.delete();
    delay = 3;
    corrupt_en = 1'b1; corrupt_from = 32'h0000_0005; corrupt_to = 32'h0002_0007;
    nx_req = 4'h1; nx_num = 32'd6; nx_start = 1'b1;
    seen = 0; n_err = 0; n_rv = 0; done_seen = 0;
    for (int c = 0; c < 100 && !done_seen; c++) begin
      cycle();
      if (o_rtt_valid) begin
        n_rv++;
        if (o_rtt_id == 32'h0002_0007) begin
          seen++;
          check("mm_err", {31'b0, o_err}, 32'd1);
          check("mm_outst", {29'b0, o_outstanding}, 32'd0);
        end
      end
      if (o_err) n_err++;
      if (o_done) done_seen = 1'b1;
    end
    corrupt_en = 1'b0;
    nx_req = '0;
    check("mm_done", {31'b0, done_seen}, 32'd1);
    check("mm_seen", seen, 32'd1);
    check("mm_err_count", n_err, 32'd1);
    check("mm_rv_count", n_rv, 32'd6);
    man_wen = 1'b1; man_id = 32'h0000_1234; man_cnt = 32'd0;
    cycle();
    cycle();
    check("empty_err", {31'b0, o_err}, 32'd1);
    check("empty_rv", {31'b0, o_rtt_valid}, 32'd0);
    check("empty_outst", {29'b0, o_outstanding}, 32'd0);

    // ---- RTT across counter wrap: stamp 0xFFFF_FFFE returned at count 4 ----
    do_reset();
    chain_q.delete();
    loop_en = 1'b0;
    nx_req = 4'h1; nx_num = 32'd1; nx_start = 1'b1;
    cycle();
    cycle();
    check("wrap_grant", {28'b0, o_grant}, 32'd1);
    cycle();
    check("wrap_cnt", o_clk_cnt, 32'd2);
    nx_req = '0;
    man_wen = 1'b1; man_id = 32'h0000_0000; man_cnt = 32'hFFFF_FFFE;
    cycle();
    cycle();
    check("wrap_rv", {31'b0, o_rtt_valid}, 32'd1);
    check("wrap_rtt", o_rtt, 32'd6);
    check("wrap_err", {31'b0, o_err}, 32'd0);
    cycle();
    check("wrap_done", {31'b0, o_done}, 32'd1);
    cycle();
    chain_q.delete();
    loop_en = 1'b1;

    // ---- asynchronous reset with two tokens in flight ----
    do_reset();
    chain_q.delete();
    delay = 20;
    nx_req = 4'h1; nx_num = 32'd4; nx_start = 1'b1;
    cycle();
    cycle();
    cycle();
    nx_req = '0;
    cycle();
    check("mid_outst", {29'b0, o_outstanding}, 32'd2);
    check("mid_busy", {31'b0, o_busy}, 32'd1);
    #2;
    nx_rstn = 1'b0;
    i_rstn  = 1'b0;
    #1;
    check("async_flags", {26'b0, o_wen, o_rtt_valid, o_err, o_done, o_busy, 1'b0} | {28'b0, o_grant}, 32'd0);
    check("async_outst", {29'b0, o_outstanding}, 32'd0);
    check("async_token", o_token, 32'd0);
    check("async_cnt", o_clk_cnt, 32'd0);
    check("async_id", o_id, 32'd0);
    check("async_rtt", o_rtt | o_rtt_id, 32'd0);
    cycle();
    cycle();
    nx_rstn = 1'b1;
    cycle();
    n_err = 0; n_rv = 0; max_o = 0;
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (o_err) n_err++;
      if (o_rtt_valid) n_rv++;
      if (int'(o_outstanding) > max_o) max_o = int'(o_outstanding);
    end
    check("stale_err_count", n_err, 32'd2);
    check("stale_rv_count", n_rv, 32'd0);
    check("stale_outst", max_o, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
